// File: rtl/key_pkg.sv
// Shared definitions for the key scheduling controller: data widths and FSM state encoding.
package key_pkg;

  localparam int KEY_W = 128;
  localparam int CRC_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/key_sched_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the requester granted last loses the next tie.
module rr_arb2
  import key_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic [1:0] i_served,
  output logic [1:0] o_pick
);

  logic r_prio1;

  // Select one requester; only a simultaneous request consults the pointer.
  always_comb begin
    o_pick = 2'b00;
    case (i_req)
      2'b01:   o_pick = 2'b01;
      2'b10:   o_pick = 2'b10;
      2'b11:   o_pick = r_prio1 ? 2'b10 : 2'b01;
      default: o_pick = 2'b00;
    endcase
  end

  // Pointer moves away from whichever requester just received its grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio1 <= 1'b0;
    end else if (i_served[0]) begin
      r_prio1 <= 1'b1;
    end else if (i_served[1]) begin
      r_prio1 <= 1'b0;
    end else begin
      r_prio1 <= r_prio1;
    end
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// Key scheduling controller: serves TX/RX key requests and periodic rekeys through the keygen,
// latching the produced keys and tracking load epochs and keygen timeouts.
module key_sched_ctrl
  import key_pkg::*;
#(
  parameter int REKEY_PERIOD = 1024,
  parameter int TIMEOUT      = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  output logic [1:0]       grant,
  output logic             kg_generate,
  input  logic [KEY_W-1:0] kg_aes_key,
  input  logic [CRC_W-1:0] kg_crc_key,
  input  logic             kg_key_valid,
  input  logic             kg_busy,
  output logic [KEY_W-1:0] aes_key,
  output logic [CRC_W-1:0] crc_key,
  output logic             key_ready,
  output logic [7:0]       epoch,
  output logic             busy,
  output logic             err
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RK_W = (REKEY_PERIOD > 1) ? $clog2(REKEY_PERIOD) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [RK_W-1:0] RK_LAST = RK_W'((REKEY_PERIOD > 0) ? REKEY_PERIOD - 1 : 0);
  localparam bit REKEY_EN = (REKEY_PERIOD > 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_winner;
  logic             r_kv_prev;
  logic [TO_W-1:0]  r_to_cnt;
  logic [RK_W-1:0]  r_rk_cnt;
  logic             r_rk_pend;
  logic             r_kg_gen;
  logic             r_busy;
  logic [1:0]       r_grant;
  logic [KEY_W-1:0] r_aes_key;
  logic [CRC_W-1:0] r_crc_key;
  logic             r_key_ready;
  logic [7:0]       r_epoch;
  logic             r_err;

  logic [1:0]       w_pick;
  logic             w_pending;
  logic             w_complete;
  logic             w_timeout;
  logic             w_start_rekey;
  logic             w_gen_nxt;
  logic             w_busy_nxt;
  logic             w_load;
  logic             w_fail;
  logic [1:0]       w_grant_nxt;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req),
    .i_served (r_grant),
    .o_pick   (w_pick)
  );

  // A held-high valid from the previous key must never count; only a fresh rising edge completes.
  assign w_pending     = (req != 2'b00) | r_rk_pend;
  assign w_complete    = kg_key_valid & ~r_kv_prev & ~kg_busy;
  assign w_timeout     = (r_to_cnt == TO_LAST);
  assign w_start_rekey = (r_state == ST_IDLE) & w_pending & (req == 2'b00);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) w_state_nxt = ST_START;
        else           w_state_nxt = ST_IDLE;
      end
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_complete)     w_state_nxt = ST_LOAD;
        else if (w_timeout) w_state_nxt = ST_ERR;
        else                w_state_nxt = ST_WAIT;
      end
      ST_LOAD: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each is valid for the whole cycle of its state.
  always_comb begin
    w_gen_nxt  = (w_state_nxt == ST_START);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_load     = (w_state_nxt == ST_LOAD);
    w_fail     = (w_state_nxt == ST_ERR);
    if (w_load) w_grant_nxt = r_winner & req;
    else        w_grant_nxt = 2'b00;
  end

  // Output registers; keys move as a whole on entry to LOAD and nowhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kg_gen    <= 1'b0;
      r_busy      <= 1'b0;
      r_grant     <= 2'b00;
      r_aes_key   <= {KEY_W{1'b0}};
      r_crc_key   <= {CRC_W{1'b0}};
      r_key_ready <= 1'b0;
      r_epoch     <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      r_kg_gen <= w_gen_nxt;
      r_busy   <= w_busy_nxt;
      r_grant  <= w_grant_nxt;
      if (w_load) begin
        r_aes_key   <= kg_aes_key;
        r_crc_key   <= kg_crc_key;
        r_key_ready <= 1'b1;
        r_epoch     <= r_epoch + 8'd1;
        r_err       <= 1'b0;
      end else if (w_fail) begin
        r_err <= 1'b1;
      end
    end
  end

  // Winner capture, valid edge history and keygen timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_winner  <= 2'b00;
      r_kv_prev <= 1'b0;
      r_to_cnt  <= {TO_W{1'b0}};
    end else begin
      r_kv_prev <= kg_key_valid;
      if ((r_state == ST_IDLE) && w_pending) r_winner <= w_pick;
      if (r_state == ST_START)     r_to_cnt <= {TO_W{1'b0}};
      else if (r_state == ST_WAIT) r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
    end
  end

  // Rekey timer runs only while idle with valid keys; once pending it waits for a free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rk_cnt  <= {RK_W{1'b0}};
      r_rk_pend <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      r_rk_cnt <= {RK_W{1'b0}};
    end else if (w_start_rekey) begin
      r_rk_pend <= 1'b0;
    end else if (REKEY_EN && (r_state == ST_IDLE) && r_key_ready && !r_rk_pend) begin
      if (r_rk_cnt == RK_LAST) r_rk_pend <= 1'b1;
      else                     r_rk_cnt  <= r_rk_cnt + {{(RK_W-1){1'b0}}, 1'b1};
    end
  end

  assign grant       = r_grant;
  assign kg_generate = r_kg_gen;
  assign aes_key     = r_aes_key;
  assign crc_key     = r_crc_key;
  assign key_ready   = r_key_ready;
  assign epoch       = r_epoch;
  assign busy        = r_busy;
  assign err         = r_err;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl with a behavioural keygen, a transaction-level reference
// model compared every cycle, and hand-computed expectations for latencies and key values.
module tb_key_sched_ctrl;

  localparam int RK  = 16;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [1:0]   grant;
  logic         kg_generate;
  logic [127:0] kg_aes_key;
  logic [15:0]  kg_crc_key;
  logic         kg_key_valid;
  logic         kg_busy;
  logic [127:0] aes_key;
  logic [15:0]  crc_key;
  logic         key_ready;
  logic [7:0]   epoch;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  key_sched_ctrl #(.REKEY_PERIOD(RK), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .kg_generate(kg_generate),
    .kg_aes_key(kg_aes_key), .kg_crc_key(kg_crc_key), .kg_key_valid(kg_key_valid),
    .kg_busy(kg_busy), .aes_key(aes_key), .crc_key(crc_key), .key_ready(key_ready),
    .epoch(epoch), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural keygen: after a generate it drops valid (optionally late), then raises a new key.
  int          kg_left = 0;
  int          kg_delay = 3;
  int          kg_lag = 0;
  bit          kg_respond = 1'b1;
  logic [31:0] kg_cnt = 32'd0;

  initial begin
    kg_key_valid = 1'b0; kg_busy = 1'b0; kg_aes_key = 128'd0; kg_crc_key = 16'd0;
    forever begin
      @(posedge clk); #1;
      if (kg_left > 0) begin
        kg_left = kg_left - 1;
        if (kg_left == 0) begin
          kg_cnt       = kg_cnt + 32'd1;
          kg_aes_key   = {4{kg_cnt}};
          kg_crc_key   = 16'hBEE0 + kg_cnt[15:0];
          kg_key_valid = 1'b1;
          kg_busy      = 1'b0;
        end else if (kg_left <= kg_delay - 1 - kg_lag) begin
          kg_key_valid = 1'b0;
          kg_busy      = 1'b1;
        end
      end
      if (kg_generate && kg_respond) kg_left = kg_delay;
    end
  end

  // Reference model: an operation is tracked by its age since the generate pulse.
  logic         e_gen, e_ready, e_busy, e_err;
  logic [1:0]   e_grant;
  logic [127:0] e_aes;
  logic [15:0]  e_crc;
  logic [7:0]   e_epoch;
  int           m_age, m_who, m_last, m_rk_cnt;
  bit           m_done, m_rk_pend, m_prev_kv;

  task automatic m_reset();
    e_gen = 1'b0; e_ready = 1'b0; e_busy = 1'b0; e_err = 1'b0; e_grant = 2'b00;
    e_aes = 128'd0; e_crc = 16'd0; e_epoch = 8'd0;
    m_age = 0; m_who = 0; m_last = 1; m_rk_cnt = 0;
    m_done = 1'b0; m_rk_pend = 1'b0; m_prev_kv = 1'b0;
  endtask

  task automatic m_step();
    bit rk_was;
    bit still_req;
    e_gen = 1'b0;
    e_grant = 2'b00;
    if (!e_busy) begin
      rk_was = m_rk_pend;
      if (req != 2'b00 || rk_was) begin
        if (req == 2'b11)      m_who = (m_last == 0) ? 1 : 0;
        else if (req == 2'b01) m_who = 0;
        else if (req == 2'b10) m_who = 1;
        else begin m_who = -1; m_rk_pend = 1'b0; end
        e_busy = 1'b1; e_gen = 1'b1; m_age = 0; m_done = 1'b0;
      end
      if (e_ready && !rk_was) begin
        if (m_rk_cnt == RK - 1) m_rk_pend = 1'b1;
        else                    m_rk_cnt = m_rk_cnt + 1;
      end
    end else if (m_done) begin
      e_busy = 1'b0; m_done = 1'b0;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (kg_key_valid && !m_prev_kv && !kg_busy) begin
      e_aes = kg_aes_key; e_crc = kg_crc_key; e_ready = 1'b1;
      e_epoch = e_epoch + 8'd1; e_err = 1'b0; m_rk_cnt = 0; m_done = 1'b1;
      still_req = (m_who == 0) ? req[0] : req[1];
      if (m_who >= 0 && still_req) begin
        e_grant = (m_who == 0) ? 2'b01 : 2'b10;
        m_last = m_who;
      end
    end else if (m_age == TMO) begin
      e_err = 1'b1; m_done = 1'b1;
    end else begin
      m_age = m_age + 1;
    end
    m_prev_kv = kg_key_valid;
  endtask

  // Compare process: every falling edge checks the DUT against the model, then advances it.
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (rst) m_reset();
      chk("m_gen",   128'(kg_generate), 128'(e_gen));
      chk("m_grant", 128'(grant),       128'(e_grant));
      chk("m_aes",   aes_key,           e_aes);
      chk("m_crc",   128'(crc_key),     128'(e_crc));
      chk("m_ready", 128'(key_ready),   128'(e_ready));
      chk("m_epoch", 128'(epoch),       128'(e_epoch));
      chk("m_busy",  128'(busy),        128'(e_busy));
      chk("m_err",   128'(err),         128'(e_err));
      if (!rst) m_step();
    end
  end

  function automatic bit cond_met(input int what, input logic [7:0] tgt);
    case (what)
      0:       return kg_generate;
      1:       return grant != 2'b00;
      2:       return err;
      default: return epoch == tgt;
    endcase
  endfunction

  task automatic wait_for(input int what, input logic [7:0] tgt, input int max,
                          input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!cond_met(what, tgt) && n < max);
    chk(name, 128'(cond_met(what, tgt)), 128'd1);
  endtask

  task automatic zeros(input string tag);
    chk({tag, "_busy"},  128'(busy),        128'd0);
    chk({tag, "_gen"},   128'(kg_generate), 128'd0);
    chk({tag, "_grant"}, 128'(grant),       128'd0);
    chk({tag, "_aes"},   aes_key,           128'd0);
    chk({tag, "_crc"},   128'(crc_key),     128'd0);
    chk({tag, "_ready"}, 128'(key_ready),   128'd0);
    chk({tag, "_epoch"}, 128'(epoch),       128'd0);
    chk({tag, "_err"},   128'(err),         128'd0);
  endtask

  initial begin
    int n;
    logic [1:0] exp_g [3];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    rst = 1'b1; req = 2'b00;
    repeat (3) @(negedge clk);
    zeros("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Single TX request: generate one cycle later, grant 4 cycles after generate.
    @(posedge clk); #1 req = 2'b01;
    @(negedge clk); chk("gen_same_cycle", 128'(kg_generate), 128'd0);
    @(negedge clk); chk("gen_next_cycle", 128'(kg_generate), 128'd1);
    wait_for(1, 8'd0, 20, "first_grant_seen", n);
    chk("first_latency", 128'(n), 128'd4);
    chk("first_grant", 128'(grant), 128'd1);
    chk("first_ready", 128'(key_ready), 128'd1);
    chk("first_epoch", 128'(epoch), 128'd1);
    chk("first_aes", aes_key, 128'h00000001_00000001_00000001_00000001);
    chk("first_crc", 128'(crc_key), 128'hBEE1);
    @(posedge clk); #1 req = 2'b00;
    @(negedge clk); chk("grant_one_cycle", 128'(grant), 128'd0);

    // Both requesters held: round-robin order from reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_for(1, 8'd0, 30, "rr_grant_seen", n);
      chk("rr_grant", 128'(grant), 128'(exp_g[i]));
      chk("rr_epoch", 128'(epoch), 128'(i + 1));
    end
    @(posedge clk); #1 req = 2'b00;

    // Idle with valid keys: automatic rekey, no grant.
    wait_for(0, 8'd0, 40, "rekey_gen_seen", n);
    chk("rekey_delay", 128'(n), 128'd18);
    wait_for(3, 8'd4, 20, "rekey_load_seen", n);
    chk("rekey_grant", 128'(grant), 128'd0);
    chk("rekey_aes", aes_key, 128'h00000005_00000005_00000005_00000005);
    kg_respond = 1'b0;

    // Silent keygen: timeout, keys kept, then retried.
    @(posedge clk); #1 req = 2'b10;
    wait_for(0, 8'd0, 10, "to_gen_seen", n);
    chk("to_gen_delay", 128'(n), 128'd2);
    wait_for(2, 8'd0, 20, "to_err_seen", n);
    chk("to_err_delay", 128'(n), 128'd9);
    chk("to_ready_kept", 128'(key_ready), 128'd1);
    chk("to_epoch_kept", 128'(epoch), 128'd4);
    chk("to_aes_kept", aes_key, 128'h00000005_00000005_00000005_00000005);
    chk("to_no_grant", 128'(grant), 128'd0);
    kg_respond = 1'b1;
    wait_for(0, 8'd0, 10, "retry_gen_seen", n);
    chk("retry_gen_delay", 128'(n), 128'd2);
    wait_for(1, 8'd0, 20, "retry_grant_seen", n);
    chk("retry_grant", 128'(grant), 128'd2);
    chk("retry_err_clr", 128'(err), 128'd0);
    chk("retry_epoch", 128'(epoch), 128'd5);
    kg_delay = 5; kg_lag = 2;

    // Valid still high from the previous key when generate fires: wait for a fresh edge.
    @(posedge clk); #1 req = 2'b01;
    wait_for(0, 8'd0, 10, "stale_gen_seen", n);
    wait_for(1, 8'd0, 20, "stale_grant_seen", n);
    chk("stale_latency", 128'(n), 128'd6);
    chk("stale_grant", 128'(grant), 128'd1);
    chk("stale_epoch", 128'(epoch), 128'd6);
    kg_delay = 3; kg_lag = 0;

    // Winner withdraws mid-operation: load still happens, no grant.
    @(posedge clk); #1 req = 2'b00;
    @(posedge clk); #1 req = 2'b01;
    wait_for(0, 8'd0, 10, "wd_gen_seen", n);
    @(posedge clk); #1 req = 2'b00;
    wait_for(3, 8'd7, 20, "wd_load_seen", n);
    chk("wd_no_grant", 128'(grant), 128'd0);
    chk("wd_aes", aes_key, 128'h00000008_00000008_00000008_00000008);

    // Reset during WAIT: immediate clear; the late completion edge is ignored.
    @(posedge clk); #1 req = 2'b10;
    wait_for(0, 8'd0, 10, "rw_gen_seen", n);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1; req = 2'b00;
    #1 zeros("rst_wait");
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_epoch", 128'(epoch), 128'd0);
    chk("post_rst_ready", 128'(key_ready), 128'd0);
    chk("post_rst_busy", 128'(busy), 128'd0);
    chk("post_rst_kv_seen", 128'(kg_key_valid), 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 The block SHALL have parameter REKEY_PERIOD, default 1024, cycles between automatic rekeys after a successful load (0 disables rekey).
REQ-002 The block SHALL have parameter TIMEOUT, default 256, maximum cycles to wait for keygen completion.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  2  per-requester key request (bit0 = TX wrapper, bit1 = RX wrapper), level; held until granted.
REQ-006 grant  output  2  one-hot, one-cycle pulse to the requester whose request was served.
REQ-007 kg_generate  output  1  one-cycle start pulse to keygen_lfsr_fsm generate_key.
REQ-008 kg_aes_key  input  128  keygen AES key.
REQ-009 kg_crc_key  input  16  keygen CRC key.
REQ-010 kg_key_valid  input  1  keygen key_valid.
REQ-011 kg_busy  input  1  keygen busy.
REQ-012 aes_key  output  128  latched AES key.
REQ-013 crc_key  output  16  latched CRC key.
REQ-014 key_ready  output  1  level; latched keys are valid.
REQ-015 epoch  output  8  count of successful key loads, wraps 255->0.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have states IDLE, START, WAIT, LOAD, ERR.
REQ-019 IDLE: pending source (req[0], req[1] or internal rekey) -> START; arbitration winner registered on this transition.
REQ-020 Arbitration: round-robin between req[0] and req[1] (last-served loses ties; after reset req[0] wins); rekey served only when req == 2'b00.
REQ-021 START: kg_generate=1 for exactly this one cycle, timeout counter cleared, unconditionally -> WAIT.
REQ-022 WAIT: completion = rising edge of kg_key_valid (registered previous value 0, current 1) with kg_busy=0 -> LOAD; stale high kg_key_valid is never completion.
REQ-023 WAIT: timeout counter reaching TIMEOUT-1 without completion -> ERR.
REQ-024 LOAD (one cycle): aes_key<=kg_aes_key, crc_key<=kg_crc_key, key_ready<=1, epoch<=epoch+1, grant pulse to winner (none for rekey), rekey timer cleared, err cleared -> IDLE.
REQ-025 Latency: request seen in IDLE at cycle N -> kg_generate at N+1; grant at 1 cycle after the completion edge.
REQ-026 ERR (one cycle): err<=1, key_ready and previous keys unchanged, no grant, winner's request stays pending -> IDLE (retried).
REQ-027 Rekey timer SHALL count only while key_ready=1 and state=IDLE, setting rekey pending at REKEY_PERIOD-1 and holding; pending cleared on entering START for rekey.
REQ-028 Requests arriving while busy=1 SHALL be held, never dropped, and arbitrated on return to IDLE.
REQ-029 Requests deasserted before winning SHALL be ignored; a winner deasserting mid-operation still completes the load, with no grant pulse.
REQ-030 During the load, aes_key/crc_key SHALL change only in the LOAD cycle and never partially.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, kg_generate=0, grant=0, aes_key=0, crc_key=0, key_ready=0, epoch=0, busy=0, err=0, timers cleared, rekey pending cleared, round-robin pointer favouring req[0].
REQ-032 Reset mid-operation SHALL abandon the transaction; a later keygen completion edge SHALL be ignored in IDLE.

Structure
REQ-033 FSM state encodings, KEY_W=128 and CRC_W=16 SHALL live in a shared package key_pkg.
REQ-034 Round-robin arbitration SHALL be one sub-module rr_arb2 (2 requests, 1-cycle pointer update on grant); all else in key_sched_ctrl.

Verification
REQ-035 req=01 after reset -> kg_generate 1 cycle later; on keygen valid edge, grant=01 one cycle, key_ready=1, epoch=1, aes_key equals kg_aes_key.
REQ-036 req=11 held -> grants in order 01, 10, 01, epoch 1,2,3.
REQ-037 Keygen model never asserts valid, TIMEOUT=8 -> err=1 8 cycles after WAIT entry, key_ready unchanged, kg_generate re-pulsed (retry).
REQ-038 REKEY_PERIOD=16, no requests after first load -> kg_generate ~16 cycles after LOAD, epoch=2, no grant pulse.
REQ-039 rst asserted during WAIT -> all outputs 0 immediately; subsequent valid edge produces no load, epoch=0.
REQ-040 kg_key_valid held high from previous key at START -> no LOAD until a fresh 0->1 edge.
